multi_channel_delay_line: RTL and testbench

Parametrised, multi-channel successor to the fixed-depth shift register: every channel runs through a register chain of up to `gp_max_stages` stages, and the output tap is selected at run time. The block tracks how many enabled shifts have occurred since reset or flush. It flags when the selected tap holds valid data and emits a registered output-valid strobe. It sits in the polyphase and commutator data paths wherever per-channel alignment delays must be trimmed without re-synthesis.

---
 rtl/multi_channel_delay_line_pkg.sv | 20 ++
 rtl/multi_channel_delay_line_stage.sv | 36 +++
 rtl/multi_channel_delay_line.sv | 94 +++++++++
 tb/tb_multi_channel_delay_line.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/multi_channel_delay_line_pkg.sv
// Shared helpers for run-time trimmed delay chains: delay-port width and the
// requested-delay clamp, reused by the polyphase filter top.
package multi_channel_delay_line_pkg;

    function automatic int calc_dly_width(input int max_stages);
        return $clog2(max_stages + 1);
    endfunction

    // 0 behaves as 1 and anything past the physical depth uses the deepest tap.
    function automatic int clamp_delay(input int req, input int max_stages);
        if (req < 1) begin
            return 1;
        end
        if (req > max_stages) begin
            return max_stages;
        end
        return req;
    endfunction

endpackage

// File: rtl/multi_channel_delay_line_stage.sv
// One W-bit chain stage: enable register with asynchronous active-high reset
// and a synchronous clear that takes priority over the enable.
module delay_stage_rst #(
    parameter int gp_data_width = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_ena,
    input  logic                            i_clr,
    input  logic signed [gp_data_width-1:0] i_d,
    output logic signed [gp_data_width-1:0] o_q
);

    logic signed [gp_data_width-1:0] q_q;
    logic signed [gp_data_width-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (i_clr) begin
            q_d = '0;
        end else if (i_ena) begin
            q_d = i_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign o_q = q_q;

endmodule

// File: rtl/multi_channel_delay_line.sv
// Multi-channel register delay line with a run-time selectable tap, a saturating
// fill counter and a registered output-valid strobe.
module multi_channel_delay_line
    import multi_channel_delay_line_pkg::*;
#(
    parameter int gp_data_width  = 8,
    parameter int gp_nr_channels = 2,
    parameter int gp_max_stages  = 16
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic                                          i_ena,
    input  logic                                          i_flush,
    input  logic [calc_dly_width(gp_max_stages)-1:0]      i_delay,
    input  logic [gp_nr_channels*gp_data_width-1:0]       i_data,
    output logic [gp_nr_channels*gp_data_width-1:0]       o_data,
    output logic                                          o_valid,
    output logic                                          o_fill_done,
    output logic [calc_dly_width(gp_max_stages)-1:0]      o_fill_cnt
);

    localparam int c_dly_width = calc_dly_width(gp_max_stages);
    localparam int c_idx_width = $clog2(gp_max_stages);

    logic signed [gp_data_width-1:0] stage_w [gp_nr_channels][gp_max_stages];

    logic [c_dly_width-1:0] d_eff;
    logic [c_idx_width-1:0] tap_idx;
    logic [c_dly_width-1:0] fill_cnt_q;
    logic [c_dly_width-1:0] fill_cnt_d;
    logic                   valid_q;
    logic                   valid_d;

    for (genvar c = 0; c < gp_nr_channels; c++) begin : g_chan
        for (genvar k = 0; k < gp_max_stages; k++) begin : g_stage
            logic signed [gp_data_width-1:0] stage_in;
            if (k == 0) begin : g_head
                assign stage_in = i_data[(c+1)*gp_data_width-1 -: gp_data_width];
            end else begin : g_body
                assign stage_in = stage_w[c][k-1];
            end

            delay_stage_rst #(
                .gp_data_width(gp_data_width)
            ) u_stage (
                .i_clk(i_clk),
                .i_rst(i_rst),
                .i_ena(i_ena),
                .i_clr(i_flush),
                .i_d  (stage_in),
                .o_q  (stage_w[c][k])
            );
        end
    end

    assign d_eff   = c_dly_width'(clamp_delay(int'(i_delay), gp_max_stages));
    assign tap_idx = c_idx_width'(d_eff - c_dly_width'(1));

    always_comb begin
        o_data = '0;
        for (int c = 0; c < gp_nr_channels; c++) begin
            o_data[c*gp_data_width +: gp_data_width] = stage_w[c][tap_idx];
        end
    end

    // Valid looks at the post-update count so it lines up with the tap value it announces.
    always_comb begin
        fill_cnt_d = fill_cnt_q;
        valid_d    = 1'b0;
        if (i_flush) begin
            fill_cnt_d = '0;
        end else if (i_ena) begin
            if (fill_cnt_q < c_dly_width'(gp_max_stages)) begin
                fill_cnt_d = fill_cnt_q + c_dly_width'(1);
            end
            valid_d = (fill_cnt_d >= d_eff);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fill_cnt_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            fill_cnt_q <= fill_cnt_d;
            valid_q    <= valid_d;
        end
    end

    assign o_fill_cnt  = fill_cnt_q;
    assign o_fill_done = (fill_cnt_q >= d_eff);
    assign o_valid     = valid_q;

endmodule

// File: tb/tb_multi_channel_delay_line.sv
// Directed bench for multi_channel_delay_line: W=8, two channels, depth 16.
module tb_multi_channel_delay_line;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_ena = 1'b0;
    logic        i_flush = 1'b0;
    logic [4:0]  i_delay = 5'd3;
    logic [15:0] i_data = '0;
    logic [15:0] o_data;
    logic        o_valid;
    logic        o_fill_done;
    logic [4:0]  o_fill_cnt;

    int passed = 0;
    int total  = 0;

    multi_channel_delay_line #(
        .gp_data_width (8),
        .gp_nr_channels(2),
        .gp_max_stages (16)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ena      (i_ena),
        .i_flush    (i_flush),
        .i_delay    (i_delay),
        .i_data     (i_data),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_fill_done(o_fill_done),
        .o_fill_cnt (o_fill_cnt)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Sample n: ch0 = n, ch1 = -n.
    function automatic logic [15:0] pk(input int n);
        logic [7:0] a;
        logic [7:0] b;
        a = 8'(n);
        b = 8'(-n);
        return {b, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic [15:0] d, input logic v,
                             input logic fd, input logic [4:0] cnt);
        check({tag, ".data"}, 32'(o_data), 32'(d));
        check({tag, ".valid"}, 32'(o_valid), 32'(v));
        check({tag, ".fill_done"}, 32'(o_fill_done), 32'(fd));
        check({tag, ".fill_cnt"}, 32'(o_fill_cnt), 32'(cnt));
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic shift(input int n);
        i_ena  = 1'b1;
        i_data = pk(n);
        tick();
    endtask

    task automatic stall();
        i_ena  = 1'b0;
        i_data = 16'hA5A5;
        tick();
    endtask

    initial begin
        // Power-on reset pulse, released between edges.
        #1 i_rst = 1'b1;
        #2 check_all("reset", 16'h0000, 1'b0, 1'b0, 5'd0);
        #1 i_rst = 1'b0;

        // Continuous fill at delay 3.
        shift(1);
        check_all("fill1", 16'h0000, 1'b0, 1'b0, 5'd1);
        shift(2);
        check_all("fill2", 16'h0000, 1'b0, 1'b0, 5'd2);
        shift(3);
        check_all("fill3", 16'hFF01, 1'b1, 1'b1, 5'd3);
        shift(4);
        check_all("fill4", 16'hFE02, 1'b1, 1'b1, 5'd4);

        // Raise delay to 6 at count 4: tap shows empty stage 5.
        i_ena   = 1'b0;
        i_delay = 5'd6;
        #1 check("raise.fill_done", 32'(o_fill_done), 32'd0);
        check("raise.data", 32'(o_data), 32'd0);
        shift(5);
        check_all("raise5", 16'h0000, 1'b0, 1'b0, 5'd5);
        shift(6);
        check_all("raise6", pk(1), 1'b1, 1'b1, 5'd6);

        // Four-cycle stall holds everything and drops valid.
        stall();
        check_all("stall1", pk(1), 1'b0, 1'b1, 5'd6);
        stall();
        stall();
        stall();
        check_all("stall4", pk(1), 1'b0, 1'b1, 5'd6);
        shift(7);
        check_all("resume7", pk(2), 1'b1, 1'b1, 5'd7);

        // Lowering delay takes effect immediately: stage 2 holds sample 5.
        i_ena   = 1'b0;
        i_delay = 5'd3;
        #1 check_all("lower3", pk(5), 1'b1, 1'b1, 5'd7);

        // Delay 0 acts as 1: tap is the latest enabled input.
        i_delay = 5'd0;
        #1 check("dly0.data", 32'(o_data), 32'(pk(7)));
        shift(8);
        check_all("dly0.shift", pk(8), 1'b1, 1'b1, 5'd8);

        // Delay 20 acts as 16: only 8 samples in, deepest tap still empty.
        i_ena   = 1'b0;
        i_delay = 5'd20;
        #1 check_all("dly20", 16'h0000, 1'b1, 1'b0, 5'd8);
        for (int n = 9; n <= 15; n++) shift(n);
        check_all("dly20.15", 16'h0000, 1'b0, 1'b0, 5'd15);
        shift(16);
        check_all("dly20.16", pk(1), 1'b1, 1'b1, 5'd16);
        for (int n = 17; n <= 20; n++) shift(n);
        check_all("sat20", pk(5), 1'b1, 1'b1, 5'd16);

        // Flush with enable: nothing captured, everything cleared.
        i_delay = 5'd3;
        i_flush = 1'b1;
        shift(21);
        check_all("flush", 16'h0000, 1'b0, 1'b0, 5'd0);
        i_flush = 1'b0;
        i_ena   = 1'b0;
        i_delay = 5'd1;
        #1 check("flush.stage0", 32'(o_data), 32'd0);
        i_delay = 5'd3;
        shift(22);
        shift(23);
        check_all("refill23", 16'h0000, 1'b0, 1'b0, 5'd2);
        shift(24);
        check_all("refill24", pk(22), 1'b1, 1'b1, 5'd3);
        shift(25);

        // Asynchronous reset between edges, then repeat the first fill.
        i_ena = 1'b0;
        #2 i_rst = 1'b1;
        #1 check_all("arst", 16'h0000, 1'b0, 1'b0, 5'd0);
        #1 i_rst = 1'b0;
        shift(1);
        check_all("post1", 16'h0000, 1'b0, 1'b0, 5'd1);
        shift(2);
        shift(3);
        check_all("post3", 16'hFF01, 1'b1, 1'b1, 5'd3);
        i_ena = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
